// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the program loader: state encoding, bus widths
// and the modulo-256 checksum helper.
package prog_loader_pkg;

  localparam int unsigned WORD_W = 15;
  localparam int unsigned ADR_W  = 8;
  localparam int unsigned CSUM_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] a,
                                                 input logic [CSUM_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADR_W-1:0]  mem_adr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_adr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_adr, mem_wdata
  );

endinterface

// File: rtl/prog_loader_csum_acc.sv
// Running modulo-256 sum of accepted load bytes; clear wins over add.
module csum_acc
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [CSUM_W-1:0] din,
  output logic [CSUM_W-1:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sum <= '0;
    else if (clear)  sum <= '0;
    else if (add_en) sum <= csum_add(sum, din);
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives count, word bytes and checksum, writes the
// words to program memory and releases the processor on a good checksum.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic             ph1,
  input  logic             reset,
  input  logic             start,
  prog_loader_if.master    bus,
  output logic             cpu_reset,
  output logic             load_err,
  output logic [ADR_W-1:0] words_loaded
);

  state_t            state_q, state_d;
  logic [7:0]        n_q;
  logic [6:0]        hi_q;
  logic [7:0]        lo_q;
  logic [ADR_W-1:0]  words_q;
  logic [CSUM_W-1:0] sum;
  logic              ready;
  logic              we;
  logic              arm;
  logic              xfer;

  assign xfer = bus.in_valid & ready;

  csum_acc u_csum (
    .clk    (ph1),
    .rst    (reset),
    .clear  (arm),
    .add_en (xfer),
    .din    (bus.in_data),
    .sum    (sum)
  );

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    we        = 1'b0;
    arm       = 1'b0;
    cpu_reset = 1'b1;
    load_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          arm     = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        ready = 1'b1;
        if (bus.in_valid) state_d = (bus.in_data == 8'h00) ? S_CSUM : S_HI;
      end
      S_HI: begin
        ready = 1'b1;
        if (bus.in_valid) state_d = S_LO;
      end
      S_LO: begin
        ready = 1'b1;
        if (bus.in_valid) state_d = S_WRITE;
      end
      S_WRITE: begin
        we      = 1'b1;
        state_d = (words_q + 8'd1 == n_q) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        ready = 1'b1;
        // The checksum byte itself must bring the running sum to zero.
        if (bus.in_valid)
          state_d = (csum_add(sum, bus.in_data) == '0) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        if (start) begin
          arm     = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_ERR: begin
        load_err = 1'b1;
        if (start) begin
          arm     = 1'b1;
          state_d = S_COUNT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      n_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      words_q <= '0;
    end else begin
      if (arm) words_q <= '0;
      if (xfer && state_q == S_COUNT) n_q  <= bus.in_data;
      if (xfer && state_q == S_HI)    hi_q <= bus.in_data[6:0];
      if (xfer && state_q == S_LO)    lo_q <= bus.in_data;
      if (state_q == S_WRITE)         words_q <= words_q + 8'd1;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = we;
  assign bus.mem_adr   = words_q;
  assign bus.mem_wdata = {hi_q, lo_q};
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: cycle-accurate vector table plus
// hand-written multi-cycle sequences against a memory model.
module tb_prog_loader;

  logic       ph1 = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_reset;
  logic       load_err;
  logic [7:0] words_loaded;

  prog_loader_if bus ();

  prog_loader dut (
    .ph1          (ph1),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 ph1 = ~ph1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Memory model fed by the write port, sampled on the falling edge.
  logic [14:0] mem [256];
  bit          written [256];
  int          we_count = 0;

  always @(negedge ph1) begin
    if (bus.mem_we === 1'b1) begin
      mem[bus.mem_adr]     = bus.mem_wdata;
      written[bus.mem_adr] = 1'b1;
      we_count++;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge ph1);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge ph1);
    start = 1'b1;
    @(posedge ph1);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int k;
    for (int s = 0; s < stall; s++) begin
      @(negedge ph1);
      bus.in_valid = 1'b0;
    end
    @(negedge ph1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      @(negedge ph1);
      k++;
    end
    if (k >= 20) check("in_ready_timeout", 32'd1, 32'd0);
    @(posedge ph1);
    #1 bus.in_valid = 1'b0;
  endtask

  logic [7:0] stream [$];

  task automatic send_stream(input int stall);
    foreach (stream[i]) send_byte(stream[i], stall);
  endtask

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        rdy;
    logic        we;
    logic [7:0]  adr;
    logic [14:0] wdata;
    logic        cpu;
    logic        err;
    logic [7:0]  words;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d,
                              input logic r, input logic w, input logic [7:0] a,
                              input logic [14:0] wd, input logic c, input logic e,
                              input logic [7:0] n);
    vec_t t;
    t.start = st; t.valid = v; t.data = d; t.rdy = r; t.we = w; t.adr = a;
    t.wdata = wd; t.cpu = c; t.err = e; t.words = n;
    return t;
  endfunction

  vec_t tbl [15];
  int   base;
  int   bad;

  initial begin
    // Basic load at full rate (checksum byte makes the total zero), then a
    // start in RUN, a start ignored in COUNT, a stall, and an empty load
    // with a wrong checksum ending in ERR.
    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 15'h0000, 1, 0, 8'd0);
    tbl[1]  = mk(0, 1, 8'h02, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd0);
    tbl[2]  = mk(0, 1, 8'h3F, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd0);
    tbl[3]  = mk(0, 1, 8'hA5, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd0);
    tbl[4]  = mk(0, 1, 8'hEE, 0, 1, 8'h00, 15'h3FA5, 1, 0, 8'd0);
    tbl[5]  = mk(0, 1, 8'h01, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd1);
    tbl[6]  = mk(0, 1, 8'h02, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd1);
    tbl[7]  = mk(0, 0, 8'h00, 0, 1, 8'h01, 15'h0102, 1, 0, 8'd1);
    tbl[8]  = mk(0, 1, 8'h17, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd2);
    tbl[9]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 15'h0000, 0, 0, 8'd2);
    tbl[10] = mk(1, 0, 8'h00, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd0);
    tbl[11] = mk(0, 0, 8'h00, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd0);
    tbl[12] = mk(0, 1, 8'h00, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd0);
    tbl[13] = mk(0, 1, 8'h55, 1, 0, 8'h00, 15'h0000, 1, 0, 8'd0);
    tbl[14] = mk(0, 0, 8'h00, 0, 0, 8'h00, 15'h0000, 1, 1, 8'd0);

    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    clear_model();

    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_adr", bus.mem_adr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_load_err", load_err, 0);
    check("rst_words", words_loaded, 0);
    repeat (2) @(negedge ph1);
    reset = 1'b0;
    repeat (3) @(negedge ph1);
    check("idle_hold_ready", bus.in_ready, 0);
    check("idle_hold_cpu", cpu_reset, 1);

    for (int i = 0; i < 15; i++) begin
      @(negedge ph1);
      start        = tbl[i].start;
      bus.in_valid = tbl[i].valid;
      bus.in_data  = tbl[i].data;
      #1;
      check($sformatf("v%0d_ready", i), bus.in_ready, tbl[i].rdy);
      check($sformatf("v%0d_we", i), bus.mem_we, tbl[i].we);
      if (tbl[i].we) begin
        check($sformatf("v%0d_adr", i), bus.mem_adr, tbl[i].adr);
        check($sformatf("v%0d_wdata", i), bus.mem_wdata, tbl[i].wdata);
      end
      check($sformatf("v%0d_cpu", i), cpu_reset, tbl[i].cpu);
      check($sformatf("v%0d_err", i), load_err, tbl[i].err);
      check($sformatf("v%0d_words", i), words_loaded, tbl[i].words);
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;

    // Bad checksum: one write of zero, then ERR.
    do_reset();
    clear_model();
    base = we_count;
    pulse_start();
    stream = '{8'h01, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    check("bad_we_count", we_count - base, 1);
    check("bad_mem0", {written[0], mem[0]}, {1'b1, 15'h0000});
    check("bad_load_err", load_err, 1);
    check("bad_cpu_reset", cpu_reset, 1);
    check("bad_words", words_loaded, 1);

    // Start from ERR, then an empty load.
    base = we_count;
    pulse_start();
    check("err_restart_ready", bus.in_ready, 1);
    check("err_restart_err", load_err, 0);
    stream = '{8'h00, 8'h00};
    send_stream(0);
    check("empty_we_count", we_count - base, 0);
    check("empty_cpu_reset", cpu_reset, 0);
    check("empty_words", words_loaded, 0);

    // Basic load with three idle cycles before every byte.
    clear_model();
    base = we_count;
    pulse_start();
    stream = '{8'h02, 8'h3F, 8'hA5, 8'h01, 8'h02, 8'h17};
    send_stream(3);
    check("stall_we_count", we_count - base, 2);
    check("stall_mem0", mem[0], 15'h3FA5);
    check("stall_mem1", mem[1], 15'h0102);
    check("stall_cpu_reset", cpu_reset, 0);
    check("stall_words", words_loaded, 2);

    // Reset right after the low byte of the first word is accepted.
    clear_model();
    pulse_start();
    stream = '{8'h02, 8'h3F, 8'hA5};
    send_stream(0);
    reset = 1'b1;
    base = we_count;
    #1;
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_ready", bus.in_ready, 0);
    check("midrst_words", words_loaded, 0);
    repeat (2) @(negedge ph1);
    reset = 1'b0;
    repeat (4) @(negedge ph1);
    check("midrst_no_we", we_count - base, 0);
    check("midrst_idle", {bus.in_ready, cpu_reset}, 2'b01);
    clear_model();
    base = we_count;
    pulse_start();
    stream = '{8'h02, 8'h3F, 8'hA5, 8'h01, 8'h02, 8'h17};
    send_stream(0);
    check("reload_we_count", we_count - base, 2);
    check("reload_mem0", mem[0], 15'h3FA5);
    check("reload_mem1", mem[1], 15'h0102);
    check("reload_cpu_reset", cpu_reset, 0);

    // Restart from RUN with a full 255-word image.
    @(negedge ph1);
    start = 1'b1;
    #1 check("run_cpu_before", cpu_reset, 0);
    @(posedge ph1);
    #1 start = 1'b0;
    check("run_restart_cpu", cpu_reset, 1);
    check("run_restart_ready", bus.in_ready, 1);
    clear_model();
    base = we_count;
    stream = {};
    stream.push_back(8'hFF);
    for (int i = 0; i < 255; i++) begin
      logic [7:0] b;
      b = i[7:0];
      stream.push_back(b);
      stream.push_back(~b);
    end
    stream.push_back(8'h00);
    send_stream(0);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      logic [7:0] b;
      b = i[7:0];
      if (!written[i] || mem[i] !== {b[6:0], ~b}) bad++;
    end
    check("n255_mem_errors", bad, 0);
    check("n255_no_wrap", written[255], 0);
    check("n255_we_count", we_count - base, 255);
    check("n255_words", words_loaded, 8'd255);
    check("n255_cpu_reset", cpu_reset, 0);
    check("n255_load_err", load_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
